// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared types and helpers for the LED frame feeder:
//   feeder_state_t : frame sequencing FSM states
//   rgb_t          : packed pixel {b, g, r}, 8 bits per channel
//   GAIN_W         : brightness gain width
//   scale_chan     : one channel scaled by (gain + 1) / 256
//   scale_rgb      : all three channels scaled by the same gain
// ---------------------------------------------------------------------------
package led_pkg;

    localparam int unsigned GAIN_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_FLUSH,
        ST_KICK,
        ST_DRAIN
    } feeder_state_t;

    typedef struct packed {
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } rgb_t;

    // (c * (g + 1)) >> 8 : g = 255 is identity, g = 0 blanks the channel.
    function automatic logic [7:0] scale_chan(input logic [7:0]        c,
                                              input logic [GAIN_W-1:0] g);
        logic [GAIN_W:0]   mult;
        logic [GAIN_W+8:0] prod;
        mult = {1'b0, g} + (GAIN_W + 1)'(1);
        prod = {{(GAIN_W + 1){1'b0}}, c} * {8'd0, mult};
        return 8'(prod >> 8);
    endfunction

    function automatic rgb_t scale_rgb(input rgb_t              px,
                                       input logic [GAIN_W-1:0] g);
        rgb_t res;
        res.b = scale_chan(px.b, g);
        res.g = scale_chan(px.g, g);
        res.r = scale_chan(px.r, g);
        return res;
    endfunction

endpackage

// File: rtl/led_sync_fifo.sv
// ---------------------------------------------------------------------------
// led_sync_fifo
// Show-ahead synchronous FIFO. The head word is held in a register so it is
// presented on o_rdata without a read request; it follows a write into an
// empty FIFO or a pop one clock later.
//   clk, rst  : clock, synchronous active-high reset (FIFO empty, o_rdata = 0)
//   i_wr      : write strobe, i_wdata : write word (dropped when full)
//   i_rd      : pop strobe (ignored when empty)
//   o_rdata   : current head word, valid while !o_empty
//   o_empty, o_full, o_count : occupancy status
// DEPTH must be a power of two, at least 2.
// ---------------------------------------------------------------------------
module led_sync_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_rd,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_do_wr;
    logic             w_do_rd;
    logic [AW-1:0]    w_rd_ptr_nxt;

    assign o_empty      = (r_count == '0);
    assign o_full       = (r_count == (AW + 1)'(DEPTH));
    assign o_count      = r_count;
    assign o_rdata      = r_head;

    assign w_do_rd      = i_rd && !o_empty;
    assign w_do_wr      = i_wr && (!o_full || w_do_rd);
    assign w_rd_ptr_nxt = r_rd_ptr + AW'(1);

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end

            unique case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase

            // Head comes straight from the write port when the incoming word
            // is the only one left; otherwise from the slot behind the head.
            // When the last word is popped the stale head is simply kept.
            if (w_do_wr && (o_empty || (w_do_rd && r_count == (AW + 1)'(1)))) begin
                r_head <= i_wdata;
            end else if (w_do_rd && r_count > (AW + 1)'(1)) begin
                r_head <= r_mem[w_rd_ptr_nxt];
            end
        end
    end

endmodule

// File: rtl/led_frame_feeder.sv
// ---------------------------------------------------------------------------
// led_frame_feeder
// Once per refresh period collects LED_NUM pixels from a valid/ready stream,
// scales each channel by a brightness gain latched at frame start, stores
// the results in a show-ahead FIFO, pulses enable for the transmitter and
// waits for LED_NUM rd pops before arming for the next refresh.
//   clk, rst          : clock, synchronous active-high reset
//   pix_valid/ready   : pixel stream handshake
//   pix_data          : {B, G, R}, pix_last marks the final pixel of a frame
//   gain              : brightness, sampled when leaving IDLE
//   fifo_data_in      : FIFO head word for the transmitter
//   rd                : transmitter pop strobe
//   enable            : one-cycle burst start pulse
//   sync_err          : sticky, pix_last misplaced within a frame
//   underflow         : sticky, rd seen while the FIFO was empty
//   overrun_cnt       : saturating count of dropped refresh ticks
// ---------------------------------------------------------------------------
module led_frame_feeder
    import led_pkg::*;
#(
    parameter int unsigned LED_NUM     = 4,
    parameter int unsigned REFRESH_CNT = 150000,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [23:0] pix_data,
    input  logic        pix_last,
    input  logic [7:0]  gain,
    output logic [23:0] fifo_data_in,
    input  logic        rd,
    output logic        enable,
    output logic        sync_err,
    output logic        underflow,
    output logic [7:0]  overrun_cnt
);

    localparam int unsigned TW  = $clog2(REFRESH_CNT);
    localparam int unsigned CW  = $clog2(LED_NUM + 1);
    localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;

    // Refresh timer and tick bookkeeping
    logic [TW-1:0]     r_timer;
    logic              r_tick_pend;
    logic [7:0]        r_overrun;
    logic              w_wrap;
    logic              w_consume;

    // FSM
    feeder_state_t     r_state;
    feeder_state_t     w_state_nxt;
    logic              r_pix_ready;
    logic              r_enable;
    logic              w_pix_ready_nxt;
    logic              w_enable_nxt;

    // Frame datapath
    logic [GAIN_W-1:0] r_gain_q;
    logic [CW-1:0]     r_pix_idx;
    logic [CW-1:0]     r_rd_cnt;
    logic              r_sync_err;
    logic              r_underflow;
    logic              r_sc_valid;
    rgb_t              r_sc_data;
    logic              w_accept;
    logic              w_last_idx;
    rgb_t              w_pix_in;

    // FIFO
    logic [23:0]       w_fifo_rdata;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic [FCW-1:0]    w_fifo_count;
    logic              w_fifo_status_unused;

    assign w_wrap     = (r_timer == TW'(REFRESH_CNT - 1));
    assign w_consume  = (r_state == ST_IDLE) && r_tick_pend;
    assign w_accept   = pix_valid && r_pix_ready;
    assign w_last_idx = (r_pix_idx == CW'(LED_NUM - 1));
    assign w_pix_in   = rgb_t'(pix_data);

    // Writes are dropped internally when full, and the FIFO is empty on
    // every FILL entry, so occupancy is not needed here.
    assign w_fifo_status_unused = ^{w_fifo_full, w_fifo_count};

    // ---------------------------------------------------------------------
    // FSM: state register (outputs registered from the next state so that
    // pix_ready / enable are high exactly while in FILL / KICK)
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pix_ready <= 1'b0;
            r_enable    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pix_ready <= w_pix_ready_nxt;
            r_enable    <= w_enable_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (r_tick_pend)             w_state_nxt = ST_FILL;
            ST_FILL:  if (w_accept && w_last_idx)  w_state_nxt = ST_FLUSH;
            ST_FLUSH:                              w_state_nxt = ST_KICK;
            ST_KICK:                               w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (rd && r_rd_cnt == CW'(LED_NUM - 1))
                                                   w_state_nxt = ST_IDLE;
            default:                               w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_pix_ready_nxt = 1'b0;
        w_enable_nxt    = 1'b0;
        if (w_state_nxt == ST_FILL) begin
            w_pix_ready_nxt = 1'b1;
        end
        if (w_state_nxt == ST_KICK) begin
            w_enable_nxt = 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Refresh timer. A wrap in the same cycle that IDLE consumes the pending
    // tick re-arms it without counting an overrun.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer     <= '0;
            r_tick_pend <= 1'b0;
            r_overrun   <= '0;
        end else if (w_wrap) begin
            r_timer     <= '0;
            r_tick_pend <= 1'b1;
            if (r_tick_pend && !w_consume && r_overrun != 8'hFF) begin
                r_overrun <= r_overrun + 8'd1;
            end
        end else begin
            r_timer <= r_timer + TW'(1);
            if (w_consume) begin
                r_tick_pend <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Frame datapath: gain latch, pixel / pop counters, error flags and the
    // one-stage scaler feeding the FIFO write port.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gain_q    <= '0;
            r_pix_idx   <= '0;
            r_rd_cnt    <= '0;
            r_sync_err  <= 1'b0;
            r_underflow <= 1'b0;
            r_sc_valid  <= 1'b0;
            r_sc_data   <= '0;
        end else begin
            if (w_consume) begin
                r_gain_q  <= gain;
                r_pix_idx <= '0;
            end else if (w_accept) begin
                r_pix_idx <= r_pix_idx + CW'(1);
            end

            // pix_last must coincide with the final pixel slot, and only it.
            if (w_accept && (pix_last != w_last_idx)) begin
                r_sync_err <= 1'b1;
            end

            if (r_state == ST_KICK) begin
                r_rd_cnt <= '0;
            end else if (r_state == ST_DRAIN && rd) begin
                r_rd_cnt <= r_rd_cnt + CW'(1);
            end

            if (rd && w_fifo_empty) begin
                r_underflow <= 1'b1;
            end

            r_sc_valid <= w_accept;
            if (w_accept) begin
                r_sc_data <= scale_rgb(w_pix_in, r_gain_q);
            end
        end
    end

    led_sync_fifo #(
        .WIDTH (24),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (r_sc_valid),
        .i_wdata (r_sc_data),
        .i_rd    (rd),
        .o_rdata (w_fifo_rdata),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full),
        .o_count (w_fifo_count)
    );

    assign pix_ready    = r_pix_ready;
    assign enable       = r_enable;
    assign fifo_data_in = w_fifo_rdata;
    assign sync_err     = r_sync_err;
    assign underflow    = r_underflow;
    assign overrun_cnt  = r_overrun;

endmodule

// File: tb/tb_led_frame_feeder.sv
// ---------------------------------------------------------------------------
// tb_led_frame_feeder
// Self-checking bench for led_frame_feeder with LED_NUM=4, REFRESH_CNT=20.
// Pixel records (gain, pixel, pix_last, expected scaled word) are listed in
// a table; expected words are queued on accept and compared against the
// FIFO head as a model transmitter pops them.
// ---------------------------------------------------------------------------
module tb_led_frame_feeder;

    localparam int unsigned LED_NUM = 4;
    localparam int unsigned REFRESH = 20;
    localparam int          BUDGET  = 200;
    localparam int          NV      = 34;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] pix_data;
    logic        pix_last;
    logic [7:0]  gain;
    logic [23:0] fifo_data_in;
    logic        rd;
    logic        enable;
    logic        sync_err;
    logic        underflow;
    logic [7:0]  overrun_cnt;

    always #5 clk = ~clk;

    led_frame_feeder #(
        .LED_NUM     (LED_NUM),
        .REFRESH_CNT (REFRESH),
        .FIFO_DEPTH  (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_data     (pix_data),
        .pix_last     (pix_last),
        .gain         (gain),
        .fifo_data_in (fifo_data_in),
        .rd           (rd),
        .enable       (enable),
        .sync_err     (sync_err),
        .underflow    (underflow),
        .overrun_cnt  (overrun_cnt)
    );

    typedef struct {
        logic [7:0]  gain;
        logic [23:0] pix;
        logic        last;
        logic [23:0] exp;
    } vec_t;

    vec_t        vec [NV];
    logic [23:0] exp_q [$];
    int          tests  = 0;
    int          fails  = 0;
    int          en_cnt = 0;

    always @(negedge clk) begin
        if (enable === 1'b1) en_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: actual timeout after %0d cycles required event", name, BUDGET);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic drive_pixel(input int idx);
        int n;
        n = 0;
        pix_valid = 1'b1;
        pix_data  = vec[idx].pix;
        pix_last  = vec[idx].last;
        while (pix_ready !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) begin
            timeout_fail("pix_ready_wait");
            pix_valid = 1'b0;
            return;
        end
        exp_q.push_back(vec[idx].exp);
        @(negedge clk);
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic wait_enable();
        int n;
        n = 0;
        while (enable !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) begin
            timeout_fail("enable_wait");
            return;
        end
        @(negedge clk);
        check("enable_one_cycle", {31'd0, enable}, 32'd0);
    endtask

    task automatic pop_words(input int n);
        logic [23:0] e;
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) begin
                timeout_fail("scoreboard_empty");
                return;
            end
            e = exp_q.pop_front();
            check("fifo_word", {8'd0, fifo_data_in}, {8'd0, e});
            rd = 1'b1;
            @(negedge clk);
            rd = 1'b0;
        end
    endtask

    task automatic run_frame(input int base);
        int en0;
        en0  = en_cnt;
        gain = vec[base].gain;
        for (int i = 0; i < int'(LED_NUM); i++) drive_pixel(base + i);
        wait_enable();
        pop_words(LED_NUM);
        check("enable_per_frame", en_cnt - en0, 32'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_pix_ready", {31'd0, pix_ready}, 32'd0);
        check("rst_enable", {31'd0, enable}, 32'd0);
        check("rst_fifo_data_in", {8'd0, fifo_data_in}, 32'd0);
        check("rst_sync_err", {31'd0, sync_err}, 32'd0);
        check("rst_underflow", {31'd0, underflow}, 32'd0);
        check("rst_overrun_cnt", {24'd0, overrun_cnt}, 32'd0);
    endtask

    initial begin
        int en0;
        int rdy_seen;
        int n;

        // gain 255: identity
        vec[0]  = '{8'd255, 24'h010203, 1'b0, 24'h010203};
        vec[1]  = '{8'd255, 24'h020304, 1'b0, 24'h020304};
        vec[2]  = '{8'd255, 24'h030405, 1'b0, 24'h030405};
        vec[3]  = '{8'd255, 24'h040506, 1'b1, 24'h040506};
        // gain 127: halving
        vec[4]  = '{8'd127, 24'hFF8001, 1'b0, 24'h7F4000};
        vec[5]  = '{8'd127, 24'h000000, 1'b0, 24'h000000};
        vec[6]  = '{8'd127, 24'hFFFFFF, 1'b0, 24'h7F7F7F};
        vec[7]  = '{8'd127, 24'h020304, 1'b1, 24'h010102};
        // gain 0: blank
        vec[8]  = '{8'd0,   24'hFFFFFF, 1'b0, 24'h000000};
        vec[9]  = '{8'd0,   24'h123456, 1'b0, 24'h000000};
        vec[10] = '{8'd0,   24'h808080, 1'b0, 24'h000000};
        vec[11] = '{8'd0,   24'h0000FF, 1'b1, 24'h000000};
        // gain 1: only channels >= 0x80 survive as 1
        vec[12] = '{8'd1,   24'hFF807F, 1'b0, 24'h010100};
        vec[13] = '{8'd1,   24'h808080, 1'b0, 24'h010101};
        vec[14] = '{8'd1,   24'h7F7F7F, 1'b0, 24'h000000};
        vec[15] = '{8'd1,   24'hFFFFFF, 1'b1, 24'h010101};
        // misplaced pix_last (on 2nd, missing on 4th)
        vec[16] = '{8'd255, 24'h112233, 1'b0, 24'h112233};
        vec[17] = '{8'd255, 24'h445566, 1'b1, 24'h445566};
        vec[18] = '{8'd255, 24'h778899, 1'b0, 24'h778899};
        vec[19] = '{8'd255, 24'hAABBCC, 1'b0, 24'hAABBCC};
        // gain 64, frame following the underflow pulse
        vec[20] = '{8'd64,  24'h404040, 1'b0, 24'h101010};
        vec[21] = '{8'd64,  24'hFFFFFF, 1'b0, 24'h404040};
        vec[22] = '{8'd64,  24'h03FC80, 1'b0, 24'h003F20};
        vec[23] = '{8'd64,  24'h000100, 1'b1, 24'h000000};
        // partial frame cut by reset
        vec[24] = '{8'd255, 24'hAAAAAA, 1'b0, 24'hAAAAAA};
        vec[25] = '{8'd255, 24'h555555, 1'b0, 24'h555555};
        // gain 200, frame held by a stalled transmitter
        vec[26] = '{8'd200, 24'h808080, 1'b0, 24'h646464};
        vec[27] = '{8'd200, 24'hFF00FF, 1'b0, 24'hC800C8};
        vec[28] = '{8'd200, 24'h010101, 1'b0, 24'h000000};
        vec[29] = '{8'd200, 24'h102030, 1'b1, 24'h0C1925};
        // frame after the stall is released
        vec[30] = '{8'd255, 24'hDEADBE, 1'b0, 24'hDEADBE};
        vec[31] = '{8'd255, 24'h00FF00, 1'b0, 24'h00FF00};
        vec[32] = '{8'd255, 24'h123456, 1'b0, 24'h123456};
        vec[33] = '{8'd255, 24'h654321, 1'b1, 24'h654321};

        rst       = 1'b1;
        pix_valid = 1'b0;
        pix_data  = '0;
        pix_last  = 1'b0;
        gain      = '0;
        rd        = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        // Scaling across gains, in-order delivery, one enable per frame
        for (int f = 0; f < 4; f++) run_frame(f * 4);
        check("sync_err_clean", {31'd0, sync_err}, 32'd0);
        check("overrun_clean", {24'd0, overrun_cnt}, 32'd0);
        check("underflow_clean", {31'd0, underflow}, 32'd0);

        // Misplaced pix_last: flagged, frame still 4 words
        run_frame(16);
        check("sync_err_set", {31'd0, sync_err}, 32'd1);

        // rd in IDLE with an empty FIFO
        gain = vec[20].gain;
        rd   = 1'b1;
        @(negedge clk);
        rd   = 1'b0;
        check("underflow_set", {31'd0, underflow}, 32'd1);
        run_frame(20);
        check("sync_err_sticky", {31'd0, sync_err}, 32'd1);
        check("underflow_sticky", {31'd0, underflow}, 32'd1);

        // Reset after two accepts of a frame
        gain = vec[24].gain;
        drive_pixel(24);
        drive_pixel(25);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        exp_q.delete();
        rst = 1'b0;

        // Stalled transmitter: ticks pile up, no refill until drained
        en0  = en_cnt;
        gain = vec[26].gain;
        for (int i = 26; i < 30; i++) drive_pixel(i);
        wait_enable();
        rdy_seen = 0;
        for (int i = 0; i < int'(3 * REFRESH); i++) begin
            @(negedge clk);
            if (pix_ready === 1'b1) rdy_seen++;
        end
        check("overrun_after_stall", {24'd0, overrun_cnt}, 32'd2);
        check("no_fill_while_stalled", rdy_seen, 32'd0);
        pop_words(LED_NUM);
        check("enable_stall_frame", en_cnt - en0, 32'd1);
        gain = vec[30].gain;
        n = 0;
        while (pix_ready !== 1'b1 && n < 5) begin
            @(negedge clk);
            n++;
        end
        check("refill_after_drain", {31'd0, pix_ready}, 32'd1);
        run_frame(30);
        check("overrun_final", {24'd0, overrun_cnt}, 32'd2);
        check("sync_err_after_reset", {31'd0, sync_err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual time limit reached required summary");
        $fatal(1, "watchdog");
    end

endmodule
